hypervector_manipulator: RTL and testbench
==========================================

HYPERVECTOR_MANIPULATOR -- requirements
Module: hypervector_manipulator

Interface
REQ-001: Parameter HV_DIMENSION, default 2000, is the hypervector width in bits.
REQ-002: Parameter MAX_BUNDLE_CYCLES, default 5, is the manipulator mask width in bits.
REQ-003: Clk_CI  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004: Reset_RBI  input  1  is the asynchronous, active-low reset.
REQ-005: Enable_SI  input  1  SHALL qualify HypervectorIn_DI/ManipulatorIn_DI as valid for capture.
REQ-006: HypervectorIn_DI  input  [0:HV_DIMENSION-1]  is the source hypervector; index 0 is the MSB.
REQ-007: ManipulatorIn_DI  input  [0:MAX_BUNDLE_CYCLES-1]  is the manipulation mask; index 0 is the MSB.
REQ-008: HypervectorOut_DO  output  [0:HV_DIMENSION-1]  is the registered manipulated hypervector.
REQ-009: Valid_SO  output  1  SHALL be high while HypervectorOut_DO holds a result captured on the previous enabled edge.

Function
REQ-010: Manipulation rule for every j in 0..HV_DIMENSION-1: result[j] = HypervectorIn_DI[j] XOR ManipulatorIn_DI[j mod MAX_BUNDLE_CYCLES].
REQ-011: Each mask bit i SHALL flip exactly the disjoint interleaved subset {i, i+MAX_BUNDLE_CYCLES, i+2*MAX_BUNDLE_CYCLES, ...}.
REQ-012: An all-zero mask SHALL pass the input through unchanged.
REQ-013: An all-ones mask SHALL output the bitwise inverse of the input.
REQ-014: HV_DIMENSION not a multiple of MAX_BUNDLE_CYCLES: the final partial group SHALL use mask bits 0..(HV_DIMENSION mod MAX_BUNDLE_CYCLES)-1 only, with no out-of-range indexing.
REQ-015: Latency SHALL be exactly one clock.
- Enable_SI high at edge k -> HypervectorOut_DO = result of inputs at edge k, and Valid_SO = 1, both visible after edge k.
REQ-016: Enable_SI low at an edge: HypervectorOut_DO SHALL hold its value and Valid_SO SHALL go to 0.
REQ-017: Back-to-back enables SHALL give one result per cycle, with no bubbles and no stall input.
REQ-018: Outputs SHALL depend only on registered state; there SHALL be no combinational path from any input to any output.
REQ-019: The mapping of REQ-010 SHALL be generated per bit from the parameters, valid for any HV_DIMENSION >= 1 and MAX_BUNDLE_CYCLES >= 1.
REQ-020: MAX_BUNDLE_CYCLES > HV_DIMENSION: mask bits at index >= HV_DIMENSION SHALL be ignored.

Reset
REQ-021: Reset_RBI low SHALL immediately, without waiting for a clock edge, force HypervectorOut_DO to all zeros and Valid_SO to 0.
REQ-022: Reset assertion mid-stream SHALL discard any pending result.
REQ-023: The first enabled rising edge after Reset_RBI deasserts SHALL capture normally, per REQ-015.
REQ-024: Reset release SHALL be synchronised by the integrating system; the block has no internal reset synchroniser.

Verification
All scenarios use HV_DIMENSION=8, MAX_BUNDLE_CYCLES=3. Bit strings are written index 0 first.
REQ-025: Pass-through: In=10101010, Mask=000, Enable=1 -> next cycle Out=10101010, Valid=1.
REQ-026: Mask bit 0: In=10101010, Mask=100 -> Out=00111000 (bits 0, 3, 6 flipped).
REQ-027: Mask bit 1: In=10101010, Mask=010 -> Out=11100011 (bits 1, 4, 7 flipped).
REQ-028: Full inversion: In=10101010, Mask=111 -> Out=01010101.
REQ-029: Hold: after an Out=01010101 result, drive Enable=0 with new inputs -> Out stays 01010101 and Valid=0.
REQ-030: Reset mid-stream: assert Reset_RBI=0 between clock edges -> Out=00000000 and Valid=0 immediately; after release, In=11111111, Mask=001, Enable=1 -> Out=11011011.
REQ-031: Bench SHALL cover the REQ-010 rule with random stimulus at default parameters, checking every enabled cycle against a reference model.

Source files
------------

// File: rtl/hypervector_manipulator.sv
// -----------------------------------------------------------------------------
// hypervector_manipulator
//
// Applies a short repeating XOR mask to a wide hypervector and registers the
// result. Mask bit i toggles every hypervector bit j with j mod
// MAX_BUNDLE_CYCLES == i, so each mask bit owns a disjoint interleaved subset
// of the hypervector. Bit index 0 is the MSB on every vector port.
//
// Parameters
//   HV_DIMENSION       hypervector width in bits (>= 1)
//   MAX_BUNDLE_CYCLES  mask width in bits (>= 1)
//
// Ports
//   Clk_CI             clock, rising-edge active
//   Reset_RBI          asynchronous active-low reset; clears output and valid
//   Enable_SI          capture strobe for HypervectorIn_DI / ManipulatorIn_DI
//   HypervectorIn_DI   source hypervector
//   ManipulatorIn_DI   manipulation mask
//   HypervectorOut_DO  registered manipulated hypervector (one-cycle latency)
//   Valid_SO           high for the cycle after an enabled capture
// -----------------------------------------------------------------------------
module hypervector_manipulator #(
   parameter int HV_DIMENSION      = 2000,
   parameter int MAX_BUNDLE_CYCLES = 5
) (
   input  logic                          Clk_CI,
   input  logic                          Reset_RBI,
   input  logic                          Enable_SI,
   input  logic [0:HV_DIMENSION-1]       HypervectorIn_DI,
   input  logic [0:MAX_BUNDLE_CYCLES-1]  ManipulatorIn_DI,
   output logic [0:HV_DIMENSION-1]       HypervectorOut_DO,
   output logic                          Valid_SO
);

   // Stage 0: mask expansion and XOR (combinational, inputs only)
   logic [0:HV_DIMENSION-1] mask_p0;
   logic [0:HV_DIMENSION-1] hv_p0;

   // j mod MAX_BUNDLE_CYCLES is always a legal mask index, so a trailing
   // partial group simply uses the low-order mask bits, and mask bits beyond
   // HV_DIMENSION are never selected when the mask is wider than the vector.
   for (genvar j = 0; j < HV_DIMENSION; j++) begin : g_mask
      assign mask_p0[j] = ManipulatorIn_DI[j % MAX_BUNDLE_CYCLES];
   end

   assign hv_p0 = HypervectorIn_DI ^ mask_p0;

   // Stage 1: output register
   logic [0:HV_DIMENSION-1] hv_p1;
   logic                    vld_p1;

   // The result register holds across disabled cycles, so it must be cleared
   // by reset as well to give a defined all-zero output.
   always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
      if (!Reset_RBI) begin
         hv_p1  <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= Enable_SI;
         if (Enable_SI) begin
            hv_p1 <= hv_p0;
         end
      end
   end

   assign HypervectorOut_DO = hv_p1;
   assign Valid_SO          = vld_p1;

endmodule

// File: tb/tb_hypervector_manipulator.sv
module tb_hypervector_manipulator;

   localparam int SD  = 8;     // small instance dimension
   localparam int SM  = 3;     // small instance mask width
   localparam int TD  = 2;     // tiny instance: mask wider than vector
   localparam int TM  = 5;
   localparam int BD  = 2000;  // default-parameter instance
   localparam int BM  = 5;

   logic Clk;
   logic rst_n;

   logic            en_s;
   logic [0:SD-1]   in_s;
   logic [0:SM-1]   mask_s;
   logic [0:SD-1]   out_s;
   logic            vld_s;

   logic            en_t;
   logic [0:TD-1]   in_t;
   logic [0:TM-1]   mask_t;
   logic [0:TD-1]   out_t;
   logic            vld_t;

   logic            en_b;
   logic [0:BD-1]   in_b;
   logic [0:BM-1]   mask_b;
   logic [0:BD-1]   out_b;
   logic            vld_b;
   logic [0:BD-1]   exp_b;
   logic            exp_vld_b;

   int passed = 0;
   int total  = 0;

   hypervector_manipulator #(.HV_DIMENSION(SD), .MAX_BUNDLE_CYCLES(SM)) u_s (
      .Clk_CI(Clk), .Reset_RBI(rst_n), .Enable_SI(en_s),
      .HypervectorIn_DI(in_s), .ManipulatorIn_DI(mask_s),
      .HypervectorOut_DO(out_s), .Valid_SO(vld_s));

   hypervector_manipulator #(.HV_DIMENSION(TD), .MAX_BUNDLE_CYCLES(TM)) u_t (
      .Clk_CI(Clk), .Reset_RBI(rst_n), .Enable_SI(en_t),
      .HypervectorIn_DI(in_t), .ManipulatorIn_DI(mask_t),
      .HypervectorOut_DO(out_t), .Valid_SO(vld_t));

   hypervector_manipulator u_b (
      .Clk_CI(Clk), .Reset_RBI(rst_n), .Enable_SI(en_b),
      .HypervectorIn_DI(in_b), .ManipulatorIn_DI(mask_b),
      .HypervectorOut_DO(out_b), .Valid_SO(vld_b));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      rst_n  = 1'b0;
      en_s = 1'b0; in_s = '0; mask_s = '0;
      en_t = 1'b0; in_t = '0; mask_t = '0;
      en_b = 1'b0; in_b = '0; mask_b = '0;
      #2;
      chk("reset_out", out_s, 8'h00);
      chk("reset_vld", {7'd0, vld_s}, 8'd0);
      tick();
      chk("reset_hold_out", out_s, 8'h00);
      rst_n = 1'b1;

      // Pass-through, then back-to-back masked captures
      en_s = 1'b1; in_s = 8'b10101010; mask_s = 3'b000;
      tick();
      chk("passthru_out", out_s, 8'b10101010);
      chk("passthru_vld", {7'd0, vld_s}, 8'd1);
      mask_s = 3'b100;
      tick();
      chk("mask_bit0", out_s, 8'b00111000);
      mask_s = 3'b010;
      tick();
      chk("mask_bit1", out_s, 8'b11100011);
      chk("b2b_vld", {7'd0, vld_s}, 8'd1);
      mask_s = 3'b111;
      tick();
      chk("invert", out_s, 8'b01010101);

      // Hold with new inputs while disabled
      en_s = 1'b0; in_s = 8'b11111111; mask_s = 3'b101;
      tick();
      chk("hold_out", out_s, 8'b01010101);
      chk("hold_vld", {7'd0, vld_s}, 8'd0);
      tick();
      chk("hold2_out", out_s, 8'b01010101);

      // Partial final group: bits 6,7 take mask bits 0,1
      en_s = 1'b1; in_s = 8'b00000000; mask_s = 3'b110;
      tick();
      chk("partial_grp", out_s, 8'b11011011);
      in_s = 8'b00001111; mask_s = 3'b010;
      tick();
      chk("mask_bit1_b", out_s, 8'b01000110);

      // Mid-stream async reset, pending capture discarded
      in_s = 8'b11111111; mask_s = 3'b111;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out", out_s, 8'h00);
      chk("async_rst_vld", {7'd0, vld_s}, 8'd0);
      tick();
      chk("rst_discard", out_s, 8'h00);
      rst_n = 1'b1;
      in_s = 8'b11111111; mask_s = 3'b001; en_s = 1'b1;
      tick();
      chk("post_rst_out", out_s, 8'b11011011);
      chk("post_rst_vld", {7'd0, vld_s}, 8'd1);
      en_s = 1'b0;

      // Mask wider than vector: bits 2..4 of the mask have no effect
      en_t = 1'b1; in_t = 2'b00; mask_t = 5'b00111;
      tick();
      chk("wide_mask_ign", {6'd0, out_t}, 8'b00000000);
      in_t = 2'b11; mask_t = 5'b01111;
      tick();
      chk("wide_mask_b1", {6'd0, out_t}, 8'b00000010);
      en_t = 1'b0;

      // Random stimulus at default parameters against a bit-level model
      exp_b = '0; exp_vld_b = 1'b0;
      for (int c = 0; c < 40; c++) begin
         int bad;
         en_b = (c % 7 == 3) ? 1'b0 : 1'b1;
         for (int j = 0; j < BD; j++) in_b[j] = 1'($urandom);
         for (int i = 0; i < BM; i++) mask_b[i] = 1'($urandom);
         if (en_b) begin
            for (int j = 0; j < BD; j++) exp_b[j] = in_b[j] ^ mask_b[j - (j / BM) * BM];
         end
         exp_vld_b = en_b;
         tick();
         bad = -1;
         for (int j = 0; j < BD; j++) if (bad < 0 && out_b[j] !== exp_b[j]) bad = j;
         total++;
         assert (bad < 0) passed++;
         else $error("FAIL rand_out cycle %0d bit %0d observed=%b expected=%b",
                     c, bad, out_b[bad], exp_b[bad]);
         chk($sformatf("rand_vld_%0d", c), {7'd0, vld_b}, {7'd0, exp_vld_b});
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
